// File: rtl/fofb_link_pkg.sv
// -----------------------------------------------------------------------------
// fofb_link_pkg
// Shared definitions for the FOFB GTY link: 8b/10b control symbols carried in
// byte 0 of a word, bit positions of the SOF/EOF header fields, the receive
// deframer state type, counter width, and the per-word checksum helper.
// No ports; imported with "import fofb_link_pkg::*;".
// -----------------------------------------------------------------------------
package fofb_link_pkg;

   // Control symbols, valid only when the byte-0 K flag is set
   localparam logic [7:0] K_IDLE = 8'hBC;   // K28.5 comma / idle
   localparam logic [7:0] K_SOF  = 8'h1C;   // K28.0 start of frame
   localparam logic [7:0] K_EOF  = 8'hFC;   // K28.7 end of frame

   // SOF word fields: [15:8] node id, [23:16] payload length, [31:24] sequence
   localparam int SOF_NODE_LSB = 8;
   localparam int SOF_LEN_LSB  = 16;
   localparam int SOF_SEQ_LSB  = 24;

   // EOF word field: [31:16] payload checksum
   localparam int EOF_CSUM_LSB = 16;

   // Status counter geometry
   localparam int          CNT_W   = 16;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // Deframer state encodings, kept as plain constants so existing register
   // maps and older tooling that expect fixed codes keep working
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PAYLOAD = 2'd1;
   localparam logic [1:0] ST_EXP_EOF = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      PAYLOAD = ST_PAYLOAD,
      EXP_EOF = ST_EXP_EOF
   } rx_state_t;

   // Contribution of one payload word to the frame checksum: low half plus
   // high half, wrapping at 16 bits
   function automatic logic [15:0] word_csum(input logic [31:0] w);
      return w[15:0] + w[31:16];
   endfunction

endpackage

// File: rtl/fofb_sat_counter.sv
// -----------------------------------------------------------------------------
// fofb_sat_counter
// 16-bit counter that stops at all-ones instead of wrapping. Clear has
// priority over a coincident increment.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   inc    in   add one this cycle (ignored once saturated)
//   clear  in   synchronous clear to zero
//   count  out  current count
// -----------------------------------------------------------------------------
module fofb_sat_counter
   import fofb_link_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] count
);

   // Clear wins over increment; once at the maximum the count holds so the
   // status register never appears to roll back to a small value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/fofb_rx_deframer.sv
// -----------------------------------------------------------------------------
// fofb_rx_deframer
// Receive-side deframer for the FOFB GTY link. Strips SOF/EOF control framing
// from the 32-bit RX word stream, delivers indexed payload words, the frame
// header (node id, sequence number) and a per-frame good/bad verdict, and
// keeps saturating good-frame and bad-frame counters.
//
// Optional feature macro: RX_CHECKSUM_EN
//   defined   - payload checksum accumulated and compared against EOF[31:16]
//   undefined - no accumulator; verdict depends on framing and length only
//
// Parameters:
//   MAX_WORDS  largest legal payload length (1..255)
//   ADDR_W     width of data_addr, MAX_WORDS <= 2**ADDR_W
// Ports:
//   userclk_rx_usrclk2  in   RX user clock, all logic on this clock
//   reset_n             in   asynchronous active-low reset
//   link_up             in   RX reset done and aligned (already synchronous)
//   rx_data[31:0]       in   received word
//   rx_is_k[3:0]        in   K flags, only bit 0 used
//   cnt_clear           in   synchronous clear of both counters
//   data_out[31:0]      out  payload word
//   data_valid          out  data_out/data_addr valid
//   data_addr[ADDR_W-1:0] out payload word index within the frame
//   node_id[7:0]        out  node id of current/last legal frame
//   seq_num[7:0]        out  sequence number of current/last legal frame
//   frame_done          out  one-cycle end-of-frame pulse (good or bad)
//   frame_ok            out  verdict, valid with frame_done
//   frame_cnt[15:0]     out  saturating count of good frames
//   err_cnt[15:0]       out  saturating count of bad frames
// -----------------------------------------------------------------------------
module fofb_rx_deframer
   import fofb_link_pkg::*;
#(
   parameter int MAX_WORDS = 64,
   parameter int ADDR_W    = 8
)
(
   input  logic              userclk_rx_usrclk2,
   input  logic              reset_n,
   input  logic              link_up,
   input  logic [31:0]       rx_data,
   input  logic [3:0]        rx_is_k,
   input  logic              cnt_clear,
   output logic [31:0]       data_out,
   output logic              data_valid,
   output logic [ADDR_W-1:0] data_addr,
   output logic [7:0]        node_id,
   output logic [7:0]        seq_num,
   output logic              frame_done,
   output logic              frame_ok,
   output logic [15:0]       frame_cnt,
   output logic [15:0]       err_cnt
);

   localparam logic [7:0]        MAX_LEN  = 8'(MAX_WORDS);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   rx_state_t         state;
   rx_state_t         next_state;
   logic [ADDR_W-1:0] word_idx;
   logic [7:0]        remaining;

   logic [7:0] sym;
   logic [7:0] sof_len;
   logic       is_k;
   logic       is_sof;
   logic       is_eof;
   logic       is_idle;
   logic       len_legal;
   logic       last_word;
   logic       csum_match;

   logic emit;
   logic load_hdr;
   logic end_frame;
   logic end_ok;

   // Only byte 0 carries control symbols on this link
   logic unused_k_flags;
   assign unused_k_flags = ^rx_is_k[3:1];

   assign sym       = rx_data[7:0];
   assign is_k      = rx_is_k[0];
   assign is_sof    = is_k && (sym == K_SOF);
   assign is_eof    = is_k && (sym == K_EOF);
   assign is_idle   = is_k && (sym == K_IDLE);
   assign sof_len   = rx_data[SOF_LEN_LSB +: 8];
   assign len_legal = (sof_len != 8'd0) && (sof_len <= MAX_LEN);
   // remaining counts down from N, so the word arriving with remaining == 1
   // is the last payload word
   assign last_word = (remaining == 8'd1);

`ifdef RX_CHECKSUM_EN
   logic [15:0] csum_acc;

   // Running checksum of the payload seen so far; restarted by every
   // accepted header so an interrupted frame cannot leak into the next one
   always_ff @(posedge userclk_rx_usrclk2 or negedge reset_n) begin
      if (!reset_n) begin
         csum_acc <= '0;
      end else if (load_hdr) begin
         csum_acc <= '0;
      end else if (emit) begin
         csum_acc <= csum_acc + word_csum(rx_data);
      end
   end

   assign csum_match = (csum_acc == rx_data[EOF_CSUM_LSB +: 16]);
`else
   assign csum_match = 1'b1;
`endif

   // Decode the current word against the frame state. A SOF seen while a
   // frame is still open both closes the old frame as bad and, when its
   // length is legal, opens the new one in the same cycle, so a broken frame
   // never costs the following frame. Dropping the link abandons any open
   // frame without reporting it, since the partial frame was never ours to
   // judge.
   always_comb begin
      next_state = state;
      emit       = 1'b0;
      load_hdr   = 1'b0;
      end_frame  = 1'b0;
      end_ok     = 1'b0;
      if (!link_up) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (is_sof) begin
                  if (len_legal) begin
                     load_hdr   = 1'b1;
                     next_state = PAYLOAD;
                  end else begin
                     end_frame = 1'b1;
                  end
               end
            end
            PAYLOAD: begin
               if (!is_k) begin
                  emit = 1'b1;
                  if (last_word) begin
                     next_state = EXP_EOF;
                  end
               end else if (is_sof) begin
                  end_frame  = 1'b1;
                  load_hdr   = len_legal;
                  next_state = len_legal ? PAYLOAD : IDLE;
               end else if (is_idle) begin
                  // comma where payload was expected: truncated frame
                  end_frame  = 1'b1;
                  next_state = IDLE;
               end else begin
                  end_frame  = 1'b1;
                  next_state = IDLE;
               end
            end
            EXP_EOF: begin
               if (is_eof) begin
                  end_frame  = 1'b1;
                  end_ok     = csum_match;
                  next_state = IDLE;
               end else if (is_sof) begin
                  end_frame  = 1'b1;
                  load_hdr   = len_legal;
                  next_state = len_legal ? PAYLOAD : IDLE;
               end else begin
                  end_frame  = 1'b1;
                  next_state = IDLE;
               end
            end
            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

   // Single output register stage. Header fields only move on a legal SOF
   // so they keep describing the last frame that was actually accepted.
   always_ff @(posedge userclk_rx_usrclk2 or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         word_idx   <= '0;
         remaining  <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         data_addr  <= '0;
         node_id    <= '0;
         seq_num    <= '0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
      end else begin
         state      <= next_state;
         data_valid <= emit;
         frame_done <= end_frame;
         frame_ok   <= end_ok;
         if (load_hdr) begin
            node_id   <= rx_data[SOF_NODE_LSB +: 8];
            seq_num   <= rx_data[SOF_SEQ_LSB +: 8];
            remaining <= sof_len;
            word_idx  <= '0;
         end
         if (emit) begin
            data_out  <= rx_data;
            data_addr <= word_idx;
            word_idx  <= word_idx + ADDR_ONE;
            remaining <= remaining - 8'd1;
         end
      end
   end

   // Counters are fed from the registered verdict, so they move the cycle
   // after frame_done is seen
   fofb_sat_counter u_frame_cnt (
      .clk   (userclk_rx_usrclk2),
      .rst_n (reset_n),
      .inc   (frame_done & frame_ok),
      .clear (cnt_clear),
      .count (frame_cnt)
   );

   fofb_sat_counter u_err_cnt (
      .clk   (userclk_rx_usrclk2),
      .rst_n (reset_n),
      .inc   (frame_done & ~frame_ok),
      .clear (cnt_clear),
      .count (err_cnt)
   );

endmodule

// File: tb/tb_fofb_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_fofb_rx_deframer
// Bench for fofb_rx_deframer. Frames are built at transaction level; each
// driven word carries the output expected one cycle later, derived from how
// the frame was constructed (good, corrupted, truncated, interrupted, ...).
// A compare process checks every cycle against that queue. Directed frames
// with literal expectations come first, then randomized frames, then a
// stand-alone saturation run of the counter sub-module.
// Honours RX_CHECKSUM_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_fofb_rx_deframer;

   localparam int MAX_WORDS = 64;
   localparam int ADDR_W    = 8;
`ifdef RX_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        link_up;
   logic [31:0] rx_data;
   logic [3:0]  rx_is_k;
   logic        cnt_clear;
   logic [31:0] data_out;
   logic        data_valid;
   logic [ADDR_W-1:0] data_addr;
   logic [7:0]  node_id;
   logic [7:0]  seq_num;
   logic        frame_done;
   logic        frame_ok;
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;

   logic        sat_inc;
   logic        sat_clear;
   logic [15:0] sat_count;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        valid;
      logic [31:0] data;
      logic [7:0]  addr;
      logic        done;
      logic        ok;
      logic [7:0]  node;
      logic [7:0]  seq;
      logic [15:0] fcnt;
      logic [15:0] ecnt;
   } exp_t;

   exp_t exp_q[$];

   // transaction-level reference state
   logic [7:0]  m_node = 8'h00;
   logic [7:0]  m_seq  = 8'h00;
   logic [15:0] m_fcnt = 16'h0000;
   logic [15:0] m_ecnt = 16'h0000;
   bit          pend_good = 1'b0;
   bit          pend_bad  = 1'b0;

   fofb_rx_deframer #(
      .MAX_WORDS (MAX_WORDS),
      .ADDR_W    (ADDR_W)
   ) dut (
      .userclk_rx_usrclk2 (clk),
      .reset_n            (reset_n),
      .link_up            (link_up),
      .rx_data            (rx_data),
      .rx_is_k            (rx_is_k),
      .cnt_clear          (cnt_clear),
      .data_out           (data_out),
      .data_valid         (data_valid),
      .data_addr          (data_addr),
      .node_id            (node_id),
      .seq_num            (seq_num),
      .frame_done         (frame_done),
      .frame_ok           (frame_ok),
      .frame_cnt          (frame_cnt),
      .err_cnt            (err_cnt)
   );

   fofb_sat_counter u_sat (
      .clk   (clk),
      .rst_n (reset_n),
      .inc   (sat_inc),
      .clear (sat_clear),
      .count (sat_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] sat_add(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic rclr();
      return ($urandom_range(0, 59) == 0);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one word for one cycle and queue what the outputs must show the
   // cycle after it is sampled. Counters reflect verdicts one cycle older.
   task automatic applyStimulus(input logic lu, input logic [31:0] d, input logic k,
                                input logic clr, input logic e_valid, input logic [7:0] e_addr,
                                input logic e_done, input logic e_ok, input logic e_load);
      exp_t e;
      if (pend_good) m_fcnt = sat_add(m_fcnt);
      if (pend_bad)  m_ecnt = sat_add(m_ecnt);
      if (clr) begin
         m_fcnt = 16'h0000;
         m_ecnt = 16'h0000;
      end
      if (e_load) begin
         m_node = d[15:8];
         m_seq  = d[31:24];
      end
      e.valid = e_valid;
      e.data  = d;
      e.addr  = e_addr;
      e.done  = e_done;
      e.ok    = e_ok;
      e.node  = m_node;
      e.seq   = m_seq;
      e.fcnt  = m_fcnt;
      e.ecnt  = m_ecnt;
      pend_good = e_done && e_ok;
      pend_bad  = e_done && !e_ok;
      @(negedge clk);
      link_up   = lu;
      rx_data   = d;
      rx_is_k   = {3'($urandom), k};
      cnt_clear = clr;
      exp_q.push_back(e);
   endtask

   task automatic idleWord(input logic clr);
      applyStimulus(1'b1, {24'h000000, 8'hBC}, 1'b1, clr, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   // Compare process: every cycle with a queued expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("data_valid", 32'(data_valid), 32'(e.valid));
            if (e.valid) begin
               checkOutput("data_out", data_out, e.data);
               checkOutput("data_addr", 32'(data_addr), 32'(e.addr));
            end
            checkOutput("frame_done", 32'(frame_done), 32'(e.done));
            if (e.done) checkOutput("frame_ok", 32'(frame_ok), 32'(e.ok));
            checkOutput("node_id", 32'(node_id), 32'(e.node));
            checkOutput("seq_num", 32'(seq_num), 32'(e.seq));
            checkOutput("frame_cnt", 32'(frame_cnt), 32'(e.fcnt));
            checkOutput("err_cnt", 32'(err_cnt), 32'(e.ecnt));
         end
      end
   end

   // One random frame. kind: 0 good, 1 bad checksum, 2 truncated by idle,
   // 3 truncated by other K, 4 illegal length, 5 wrong word instead of EOF,
   // 6 left open (next SOF interrupts it), 7 link drop mid-frame.
   // interrupted: the SOF of this frame closes a previous open frame.
   task automatic sendFrame(input int kind, input bit interrupted, output bit open);
      int          n;
      int          cut;
      logic [7:0]  node;
      logic [7:0]  seq;
      logic [15:0] sum;
      logic [31:0] w;
      logic [7:0]  bad_syms[3];
      bad_syms = '{8'hFC, 8'h5C, 8'h7C};
      open = 1'b0;
      node = 8'($urandom);
      seq  = 8'($urandom);
      if (kind == 4) begin
         n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_WORDS + 1, 255);
         applyStimulus(1'b1, {seq, 8'(n), node, 8'h1C}, 1'b1, rclr(), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         return;
      end
      n = ($urandom_range(0, 9) == 0) ? MAX_WORDS : $urandom_range(1, 8);
      applyStimulus(1'b1, {seq, 8'(n), node, 8'h1C}, 1'b1, rclr(), 1'b0, 8'h00, interrupted, 1'b0, 1'b1);
      cut = n;
      if (kind == 2 || kind == 3 || kind == 7) cut = $urandom_range(0, n - 1);
      if (kind == 6) cut = $urandom_range(0, n);
      sum = 16'h0000;
      for (int i = 0; i < cut; i++) begin
         w = $urandom;
         sum = sum + w[15:0] + w[31:16];
         applyStimulus(1'b1, w, 1'b0, rclr(), 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      end
      case (kind)
         0: applyStimulus(1'b1, {sum, 8'($urandom), 8'hFC}, 1'b1, rclr(), 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
         1: applyStimulus(1'b1, {sum + 16'd1, 8'($urandom), 8'hFC}, 1'b1, rclr(), 1'b0, 8'h00, 1'b1, !CSUM_ON, 1'b0);
         2: applyStimulus(1'b1, {24'($urandom), 8'hBC}, 1'b1, rclr(), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         3: applyStimulus(1'b1, {24'($urandom), bad_syms[$urandom_range(0, 2)]}, 1'b1, rclr(), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         5: begin
            if ($urandom_range(0, 1) == 0)
               applyStimulus(1'b1, $urandom, 1'b0, rclr(), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            else
               applyStimulus(1'b1, {24'($urandom), 8'hBC}, 1'b1, rclr(), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         end
         6: open = 1'b1;
         7: begin
            repeat ($urandom_range(1, 3))
               applyStimulus(1'b0, $urandom, 1'($urandom), rclr(), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         end
         default: ;
      endcase
   endtask

   // Inter-frame filler that must never produce output
   task automatic sendGap();
      repeat ($urandom_range(0, 3)) begin
         case ($urandom_range(0, 3))
            0: applyStimulus(1'b1, {24'($urandom), 8'hBC}, 1'b1, rclr(), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            1: applyStimulus(1'b1, $urandom, 1'b0, rclr(), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            2: applyStimulus(1'b1, {24'($urandom), 8'hFC}, 1'b1, rclr(), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            default: applyStimulus(1'b0, $urandom, 1'($urandom), rclr(), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         endcase
      end
   endtask

   initial begin
      bit open;
      int kind;
      reset_n   = 1'b0;
      link_up   = 1'b0;
      rx_data   = '0;
      rx_is_k   = '0;
      cnt_clear = 1'b0;
      sat_inc   = 1'b0;
      sat_clear = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_data_out", data_out, 32'h0);
      checkOutput("rst_data_valid", 32'(data_valid), 32'h0);
      checkOutput("rst_data_addr", 32'(data_addr), 32'h0);
      checkOutput("rst_node_id", 32'(node_id), 32'h0);
      checkOutput("rst_seq_num", 32'(seq_num), 32'h0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
      checkOutput("rst_frame_ok", 32'(frame_ok), 32'h0);
      checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'h0);
      checkOutput("rst_err_cnt", 32'(err_cnt), 32'h0);
      reset_n = 1'b1;
      idleWord(1'b0);

      // good frame: node 5, N 3, seq 0x11, data 1,2,3, checksum 6
      applyStimulus(1'b1, 32'h1103_051C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0006_00FC, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      repeat (3) idleWord(1'b0);
      checkOutput("tp_good_frame_cnt", 32'(frame_cnt), 32'd1);
      checkOutput("tp_good_node_id", 32'(node_id), 32'h05);
      checkOutput("tp_good_seq_num", 32'(seq_num), 32'h11);

      // checksum error: same frame, EOF checksum 7
      applyStimulus(1'b1, 32'h1103_051C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0007_00FC, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, !CSUM_ON, 1'b0);
      repeat (3) idleWord(1'b0);
      checkOutput("tp_csum_err_cnt", 32'(err_cnt), CSUM_ON ? 32'd1 : 32'd0);

      // truncation: N 4, two words, then idle
      applyStimulus(1'b1, 32'h2204_211C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0000_00BC, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      repeat (3) idleWord(1'b0);
      checkOutput("tp_trunc_err_cnt", 32'(err_cnt), CSUM_ON ? 32'd2 : 32'd1);

      // length bounds: N 0 then N 65, header must not move
      applyStimulus(1'b1, 32'h3300_321C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h3441_331C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      repeat (3) idleWord(1'b0);
      checkOutput("tp_len_node_id", 32'(node_id), 32'h21);
      checkOutput("tp_len_err_cnt", 32'(err_cnt), CSUM_ON ? 32'd4 : 32'd3);

      // link drop mid-payload, then a good one-word frame
      applyStimulus(1'b1, 32'h3503_311C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0000_00FC, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0000_00BC, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h3601_411C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h9D9C_00FC, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      repeat (3) idleWord(1'b0);
      checkOutput("tp_link_frame_cnt", 32'(frame_cnt), CSUM_ON ? 32'd2 : 32'd3);
      checkOutput("tp_link_err_cnt", 32'(err_cnt), CSUM_ON ? 32'd4 : 32'd3);

      // clear coincident with a good frame_done
      applyStimulus(1'b1, 32'h3701_511C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h0001_0001, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0002_00FC, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      idleWord(1'b1);
      repeat (2) idleWord(1'b0);
      checkOutput("tp_clear_frame_cnt", 32'(frame_cnt), 32'd0);
      checkOutput("tp_clear_err_cnt", 32'(err_cnt), 32'd0);

      // randomized frames, back-to-back or with filler
      open = 1'b0;
      repeat (400) begin
         kind = open ? $urandom_range(0, 5) : $urandom_range(0, 7);
         sendFrame(kind, open, open);
         if (!open) sendGap();
      end
      while (open) sendFrame(0, 1'b1, open);
      repeat (4) idleWord(1'b0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      // saturation and clear of the counter sub-module
      @(negedge clk);
      sat_inc = 1'b1;
      repeat (100) @(negedge clk);
      checkOutput("sat_count_100", 32'(sat_count), 32'd100);
      repeat (65500) @(negedge clk);
      checkOutput("sat_count_hold", 32'(sat_count), 32'h0000FFFF);
      sat_clear = 1'b1;
      @(negedge clk);
      sat_clear = 1'b0;
      sat_inc   = 1'b0;
      checkOutput("sat_clear_vs_inc", 32'(sat_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
